sevenseg_scan_ctrl: RTL and testbench

Display controller for the Nexys4 DDR 8-digit seven-segment bank in the RSA design. It accepts binary results (plaintext, ciphertext or key values) from the RSA core over a valid/ready handshake and converts each one to eight BCD digits with a sequential double-dabble engine. It then time-multiplexes all eight anodes with leading-zero blanking and an overflow indication. It replaces the fixed two-digit toggling with a scheduled scan of the full bank.

---
 rtl/sevenseg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: a valid/ready load interface, a sequential
// double-dabble binary-to-BCD engine, and a registered anode/segment scan with leading-zero blanking.
module sevenseg_scan_ctrl #(
   parameter int REFRESH_BITS = 16,
   parameter bit ZERO_BLANK   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [26:0] load_value,
   output logic        load_ready,
   output logic [6:0]  a_to_g,
   output logic [7:0]  an,
   output logic        dp
);

   localparam logic [26:0] MAX_DISP = 27'd99_999_999;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t                  state, state_nx;
   logic [31:0]             shadow, shadow_adj, disp;
   logic [26:0]             val;
   logic [4:0]              bitcnt;
   logic                    ovf, ovf_disp;
   logic                    hs, too_big;
   logic [REFRESH_BITS-1:0] rcnt;
   logic [2:0]              idx;
   logic [7:0]              upper_zero;
   logic [3:0]              nib;
   logic [6:0]              glyph;

   assign dp      = 1'b1;
   assign hs      = load_valid & load_ready;
   assign too_big = (load_value > MAX_DISP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      load_ready = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) state_nx = too_big ? COMMIT : CONVERT;
         end
         CONVERT: if (bitcnt == 5'd1) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
   for (genvar g = 0; g < 8; g++) begin : g_adj
      assign shadow_adj[g*4 +: 4] = (shadow[g*4 +: 4] >= 4'd5) ? shadow[g*4 +: 4] + 4'd3
                                                                : shadow[g*4 +: 4];
      assign upper_zero[g] = (disp[31:g*4] == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow   <= '0;
         val      <= '0;
         bitcnt   <= '0;
         ovf      <= 1'b0;
         disp     <= '0;
         ovf_disp <= 1'b0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               shadow <= '0;
               val    <= load_value;
               bitcnt <= 5'd27;
               ovf    <= too_big;
            end
            CONVERT: begin
               shadow <= {shadow_adj[30:0], val[26]};
               val    <= {val[25:0], 1'b0};
               bitcnt <= bitcnt - 5'd1;
            end
            COMMIT: begin
               disp     <= shadow;
               ovf_disp <= ovf;
            end
            default: ;
         endcase
      end
   end

   assign idx = rcnt[REFRESH_BITS-1 -: 3];
   assign nib = disp[{idx, 2'b00} +: 4];

   always_comb begin
      glyph = 7'b1111111;
      if (ovf_disp)
         glyph = 7'b1111110;
      else if (ZERO_BLANK && (idx != 3'd0) && upper_zero[idx])
         glyph = 7'b1111111;
      else begin
         case (nib)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = 7'b1111111;
         endcase
      end
   end

   // Anode and segments are registered together so both switch on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt   <= '0;
         an     <= 8'hFF;
         a_to_g <= 7'b1111111;
      end else begin
         rcnt   <= rcnt + 1'b1;
         an     <= ~(8'b1 << idx);
         a_to_g <= glyph;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: decimal-arithmetic model checked every cycle on two
// instances (blanking on/off), plus directed literal checks of digits and ready timing.
module tb_sevenseg_scan_ctrl;

   localparam int RB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic [26:0] load_value = '0;
   logic        rdy1, rdy0, dp1, dp0;
   logic [6:0]  seg1, seg0;
   logic [7:0]  an1, an0;

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   sevenseg_scan_ctrl #(.REFRESH_BITS(RB), .ZERO_BLANK(1'b1)) u_zb1 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
      .load_ready(rdy1), .a_to_g(seg1), .an(an1), .dp(dp1));

   sevenseg_scan_ctrl #(.REFRESH_BITS(RB), .ZERO_BLANK(1'b0)) u_zb0 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
      .load_ready(rdy0), .a_to_g(seg0), .an(an0), .dp(dp0));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   int  p10 [8] = '{1, 10, 100, 1000, 10000, 100000, 1000000, 10000000};
   int  m_tick = 0, m_busy = 0, m_val = 0, m_pend = 0;
   bit  m_ovf = 0, m_povf = 0;
   logic [7:0] exp_an = 8'hFF;
   logic [6:0] exp_s1 = 7'h7F, exp_s0 = 7'h7F;
   logic       exp_rdy = 1'b1;

   function automatic logic [6:0] mglyph(input int i, input bit zb);
      if (m_ovf) return 7'b1111110;
      if (zb && i != 0 && m_val < p10[i]) return 7'b1111111;
      return SEG[(m_val / p10[i]) % 10];
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_tick = 0; m_busy = 0; m_val = 0; m_ovf = 0;
         exp_an = 8'hFF; exp_s1 = 7'h7F; exp_s0 = 7'h7F; exp_rdy = 1'b1;
      end else begin
         int i;
         i = m_tick >> (RB - 3);
         exp_an = ~(8'b1 << i);
         exp_s1 = mglyph(i, 1'b1);
         exp_s0 = mglyph(i, 1'b0);
         m_tick = (m_tick + 1) % (1 << RB);
         if (m_busy == 0) begin
            if (load_valid) begin
               m_pend = int'(load_value);
               m_povf = (m_pend > 99999999);
               m_busy = m_povf ? 1 : 28;
            end
         end else begin
            m_busy--;
            if (m_busy == 0) begin
               m_ovf = m_povf;
               m_val = m_povf ? 0 : m_pend;
            end
         end
         exp_rdy = (m_busy == 0);
      end
   end

   initial forever begin
      @(negedge clk);
      if (en) begin
         chk("an_zb1", an1, exp_an);
         chk("an_zb0", an0, exp_an);
         chk("seg_zb1", seg1, exp_s1);
         chk("seg_zb0", seg0, exp_s0);
         chk("ready", {rdy1, rdy0}, {exp_rdy, exp_rdy});
         chk("dp", {dp1, dp0}, 2'b11);
      end
   end

   // ---------------- directed ----------------
   task automatic wait_an(input int k);
      int n = 0;
      while (an1 !== ~(8'b1 << k) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("scan_timeout", an1, ~(8'b1 << k));
   endtask

   task automatic load(input int v, input int exp_low, input string nm);
      int n = 0;
      @(negedge clk);
      while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      load_valid = 1'b1;
      load_value = v[26:0];
      @(negedge clk);
      load_valid = 1'b0;
      n = 0;
      while (!rdy1 && n < 100) begin n++; @(negedge clk); end
      chk(nm, n, exp_low);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b1;
      chk("rst_an", an1, 8'hFF);
      chk("rst_seg", seg1, 7'h7F);
      chk("rst_rdy", rdy1, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("first_an", an1, 8'hFE);
      wait_an(0); chk("zero_d0", seg1, 7'b0000001);
      wait_an(3); chk("zero_d3_blank", seg1, 7'b1111111);
      chk("zero_d3_noblank", seg0, 7'b0000001);

      load(12345678, 28, "ready_low_12345678");
      wait_an(0); chk("d0_8", seg1, 7'b0000000);
      wait_an(4); chk("d4_4", seg1, 7'b1001100);
      wait_an(7); chk("d7_1", seg1, 7'b1001111);

      load(907, 28, "ready_low_907");
      wait_an(1); chk("907_mid0", seg1, 7'b0000001);
      wait_an(2); chk("907_9", seg1, 7'b0000100);
      wait_an(3); chk("907_blank", seg1, 7'b1111111);
      chk("907_noblank", seg0, 7'b0000001);

      load(100000000, 1, "ready_low_ovf");
      wait_an(5); chk("ovf_dash", seg1, 7'b1111110);
      chk("ovf_dash0", seg0, 7'b1111110);
      load(99999999, 28, "ready_low_max");
      wait_an(7); chk("max_9", seg1, 7'b0000100);
      load(134217727, 1, "ready_low_27b");
      wait_an(0); chk("27b_dash", seg1, 7'b1111110);

      // valid held high with changing data: only the handshake value sticks
      @(negedge clk);
      load_valid = 1'b1;
      load_value = 27'd11111111;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         load_value = 27'($urandom_range(0, 27'h7FFFFFF));
      end
      load_valid = 1'b0;
      begin
         int n = 0;
         while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      end
      repeat (2) @(negedge clk);
      wait_an(0); chk("hold_d0", seg1, 7'b1001111);
      wait_an(7); chk("hold_d7", seg1, 7'b1001111);

      // reset mid-conversion
      @(negedge clk);
      load_valid = 1'b1;
      load_value = 27'd76543210;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("abort_an", an1, 8'hFF);
      chk("abort_seg", seg1, 7'h7F);
      chk("abort_rdy", rdy1, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_first_an", an1, 8'hFE);
      wait_an(0); chk("abort_d0", seg1, 7'b0000001);
      wait_an(1); chk("abort_d1", seg1, 7'b1111111);
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
